// File: rtl/cdb_arbiter_if.sv
// Producer handshakes and result-bus signals shared by the three execute-end
// units, the CDB arbiter and the ROB set port.
interface cdb_arbiter_if #(
  parameter int ROB_WIDTH_BIT = 4
);
  logic                     alu_valid;
  logic [ROB_WIDTH_BIT-1:0] alu_rob_id;
  logic [31:0]              alu_val;
  logic                     alu_ready;

  logic                     lsb_valid;
  logic [ROB_WIDTH_BIT-1:0] lsb_rob_id;
  logic [31:0]              lsb_val;
  logic                     lsb_ready;

  logic                     br_valid;
  logic [ROB_WIDTH_BIT-1:0] br_rob_id;
  logic [31:0]              br_val;
  logic                     br_ready;

  logic                     cdb_valid;
  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id;
  logic [31:0]              cdb_val;
  logic [1:0]               cdb_src;
  logic [1:0]               pending;

  // Producer/consumer side.
  modport master (
    output alu_valid, alu_rob_id, alu_val,
    output lsb_valid, lsb_rob_id, lsb_val,
    output br_valid, br_rob_id, br_val,
    input  alu_ready, lsb_ready, br_ready,
    input  cdb_valid, cdb_rob_id, cdb_val, cdb_src, pending
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rob_id, alu_val,
    input  lsb_valid, lsb_rob_id, lsb_val,
    input  br_valid, br_rob_id, br_val,
    output alu_ready, lsb_ready, br_ready,
    output cdb_valid, cdb_rob_id, cdb_val, cdb_src, pending
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB result-write port between ALU, LSB and
// branch unit; one holding register per source, registered result bus.
module cdb_arbiter #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input logic          clk_in,
  input logic          rst_n_in,
  input logic          rdy_in,
  input logic          clear,
  cdb_arbiter_if.slave bus
);
  localparam int NSRC = 3;

  function automatic logic [1:0] wrap3(input logic [2:0] s);
    logic [2:0] t;
    t = (s >= 3'd3) ? (s - 3'd3) : s;
    return t[1:0];
  endfunction

  logic [NSRC-1:0]          src_valid;
  logic [ROB_WIDTH_BIT-1:0] src_id [NSRC];
  logic [31:0]              src_val [NSRC];
  logic [NSRC-1:0]          src_ready;

  logic [NSRC-1:0]          hold_valid;
  logic [ROB_WIDTH_BIT-1:0] hold_id [NSRC];
  logic [31:0]              hold_val [NSRC];

  logic [1:0]               rr_reg;
  logic                     cdb_valid_reg;
  logic [ROB_WIDTH_BIT-1:0] cdb_rob_id_reg;
  logic [31:0]              cdb_val_reg;
  logic [1:0]               cdb_src_reg;

  logic [1:0]               rr_eff;
  logic [1:0]               cand;
  logic [1:0]               grant_idx;
  logic                     grant_any;
  logic [NSRC-1:0]          grant;

  assign src_valid  = {bus.br_valid, bus.lsb_valid, bus.alu_valid};
  assign src_id[0]  = bus.alu_rob_id;
  assign src_id[1]  = bus.lsb_rob_id;
  assign src_id[2]  = bus.br_rob_id;
  assign src_val[0] = bus.alu_val;
  assign src_val[1] = bus.lsb_val;
  assign src_val[2] = bus.br_val;

  // First occupied holding register starting at the round-robin pointer.
  always_comb begin
    rr_eff    = (rr_reg == 2'd3) ? 2'd0 : rr_reg;
    cand      = 2'd0;
    grant_idx = 2'd0;
    grant_any = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      cand = wrap3({1'b0, rr_eff} + k[2:0]);
      if (!grant_any && hold_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
  end

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic                     hold_valid_reg;
    logic [ROB_WIDTH_BIT-1:0] hold_id_reg;
    logic [31:0]              hold_val_reg;

    // A register being granted this cycle can be refilled in the same cycle.
    assign src_ready[gi] = rst_n_in && rdy_in && !clear &&
                           (!hold_valid_reg || grant[gi]);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        hold_valid_reg <= 1'b0;
        hold_id_reg    <= '0;
        hold_val_reg   <= '0;
      end else if (rdy_in) begin
        if (clear) begin
          hold_valid_reg <= 1'b0;
        end else if (src_valid[gi] && src_ready[gi]) begin
          hold_valid_reg <= 1'b1;
          hold_id_reg    <= src_id[gi];
          hold_val_reg   <= src_val[gi];
        end else if (grant[gi]) begin
          hold_valid_reg <= 1'b0;
        end
      end
    end

    assign hold_valid[gi] = hold_valid_reg;
    assign hold_id[gi]    = hold_id_reg;
    assign hold_val[gi]   = hold_val_reg;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_reg         <= 2'd0;
      cdb_valid_reg  <= 1'b0;
      cdb_rob_id_reg <= '0;
      cdb_val_reg    <= '0;
      cdb_src_reg    <= 2'd0;
    end else if (rdy_in) begin
      if (clear) begin
        rr_reg        <= 2'd0;
        cdb_valid_reg <= 1'b0;
      end else if (grant_any) begin
        rr_reg         <= wrap3({1'b0, grant_idx} + 3'd1);
        cdb_valid_reg  <= 1'b1;
        cdb_rob_id_reg <= hold_id[grant_idx];
        cdb_val_reg    <= hold_val[grant_idx];
        cdb_src_reg    <= grant_idx;
      end else begin
        cdb_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.alu_ready  = src_ready[0];
  assign bus.lsb_ready  = src_ready[1];
  assign bus.br_ready   = src_ready[2];
  assign bus.cdb_valid  = cdb_valid_reg;
  assign bus.cdb_rob_id = cdb_rob_id_reg;
  assign bus.cdb_val    = cdb_val_reg;
  assign bus.cdb_src    = cdb_src_reg;
  assign bus.pending    = {1'b0, hold_valid[0]} + {1'b0, hold_valid[1]} +
                          {1'b0, hold_valid[2]};
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected results are queued as stimulus is
// driven and popped by a monitor whenever the ROB would consume a bus result.
module tb_cdb_arbiter;
  logic clk_in;
  logic rst_n_in;
  logic rdy_in;
  logic clear;

  cdb_arbiter_if #(.ROB_WIDTH_BIT(4)) bus ();

  cdb_arbiter #(.ROB_WIDTH_BIT(4)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .clear    (clear),
    .bus      (bus.slave)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] val;
    logic [1:0]  src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] rr_vals [3];

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] val, input logic [1:0] src);
    exp_t e;
    e.id = id;
    e.val = val;
    e.src = src;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // The ROB takes a result whenever the bus is valid and the core is not stalled.
  always @(negedge clk_in) begin
    if (rst_n_in && rdy_in && bus.cdb_valid) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL cdb_unexpected: observed id=%0h src=%0d expected no result",
               bus.cdb_rob_id, bus.cdb_src);
      end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        $display("cdb result: id=%0h val=%08h src=%0d", bus.cdb_rob_id, bus.cdb_val, bus.cdb_src);
        chk("cdb_rob_id", 32'(bus.cdb_rob_id), 32'(e.id));
        chk("cdb_val", bus.cdb_val, e.val);
        chk("cdb_src", 32'(bus.cdb_src), 32'(e.src));
      end
    end
  end

  task automatic set_src(input int s, input logic v, input logic [3:0] id, input logic [31:0] val);
    case (s)
      0: begin bus.alu_valid = v; bus.alu_rob_id = id; bus.alu_val = val; end
      1: begin bus.lsb_valid = v; bus.lsb_rob_id = id; bus.lsb_val = val; end
      default: begin bus.br_valid = v; bus.br_rob_id = id; bus.br_val = val; end
    endcase
  endtask

  task automatic idle_all();
    for (int s = 0; s < 3; s++) set_src(s, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    rr_vals[0] = 32'hA1A1_0001;
    rr_vals[1] = 32'hB2B2_0002;
    rr_vals[2] = 32'hC3C3_0003;
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    clear    = 1'b0;
    idle_all();

    // Reset state
    #1;
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rst_pending", 32'(bus.pending), 32'd0);
    tick();
    tick();
    rst_n_in = 1'b1;
    #1;
    chk("post_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("post_rst_lsb_ready", 32'(bus.lsb_ready), 32'd1);
    chk("post_rst_br_ready", 32'(bus.br_ready), 32'd1);
    chk("post_rst_cdb_src", 32'(bus.cdb_src), 32'd0);
    chk("post_rst_cdb_val", bus.cdb_val, 32'd0);

    // Single result: two edges to the bus, valid for one cycle
    set_src(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
    push(4'd5, 32'hDEAD_BEEF, 2'd0);
    tick();
    idle_all();
    chk("single_pending", 32'(bus.pending), 32'd1);
    chk("single_early_valid", 32'(bus.cdb_valid), 32'd0);
    tick();
    chk("single_valid", 32'(bus.cdb_valid), 32'd1);
    chk("single_id", 32'(bus.cdb_rob_id), 32'd5);
    chk("single_val", bus.cdb_val, 32'hDEAD_BEEF);
    chk("single_pending_drained", 32'(bus.pending), 32'd0);
    tick();
    chk("single_one_cycle", 32'(bus.cdb_valid), 32'd0);

    // Round-robin with all three sources continuously valid (clear resets pointer)
    clear = 1'b1;
    #1;
    chk("clear_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    clear = 1'b0;
    for (int s = 0; s < 3; s++) set_src(s, 1'b1, 4'(s + 1), rr_vals[s]);
    for (int i = 0; i < 8; i++) push(4'(i % 3 + 1), rr_vals[i % 3], 2'(i % 3));
    tick();
    chk("rr_pending_full", 32'(bus.pending), 32'd3);
    chk("rr_alu_ready_granted", 32'(bus.alu_ready), 32'd1);
    chk("rr_lsb_ready_blocked", 32'(bus.lsb_ready), 32'd0);
    chk("rr_br_ready_blocked", 32'(bus.br_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) idle_all();
      chk("rr_valid", 32'(bus.cdb_valid), 32'd1);
      chk("rr_src", 32'(bus.cdb_src), 32'(i % 3));
    end
    tick();
    chk("rr_drained_valid", 32'(bus.cdb_valid), 32'd0);
    chk("rr_drained_pending", 32'(bus.pending), 32'd0);

    // Backpressure: ALU granted with LSB and BR waiting, ALU refills in grant cycle
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_src(0, 1'b1, 4'd7, 32'h0000_0707);
    set_src(1, 1'b1, 4'd8, 32'h0000_0808);
    set_src(2, 1'b1, 4'd9, 32'h0000_0909);
    push(4'd7, 32'h0000_0707, 2'd0);
    push(4'd8, 32'h0000_0808, 2'd1);
    push(4'd9, 32'h0000_0909, 2'd2);
    push(4'd10, 32'h0000_1010, 2'd0);
    tick();
    set_src(1, 1'b0, 4'd0, 32'd0);
    set_src(2, 1'b0, 4'd0, 32'd0);
    set_src(0, 1'b1, 4'd10, 32'h0000_1010);
    #1;
    chk("bp_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("bp_lsb_ready", 32'(bus.lsb_ready), 32'd0);
    chk("bp_pending", 32'(bus.pending), 32'd3);
    tick();
    idle_all();
    chk("bp_grant_alu", 32'(bus.cdb_src), 32'd0);
    chk("bp_pending_refilled", 32'(bus.pending), 32'd3);
    tick();
    chk("bp_grant_lsb", 32'(bus.cdb_src), 32'd1);
    tick();
    chk("bp_grant_br", 32'(bus.cdb_src), 32'd2);
    chk("bp_pending_one", 32'(bus.pending), 32'd1);
    tick();
    chk("bp_grant_alu2", 32'(bus.cdb_rob_id), 32'd10);
    chk("bp_pending_zero", 32'(bus.pending), 32'd0);

    // Stall: two pending entries frozen for four cycles, then drain back to back
    set_src(1, 1'b1, 4'd11, 32'h0000_1111);
    set_src(2, 1'b1, 4'd12, 32'h0000_1212);
    push(4'd11, 32'h0000_1111, 2'd1);
    push(4'd12, 32'h0000_1212, 2'd2);
    tick();
    idle_all();
    chk("stall_pending", 32'(bus.pending), 32'd2);
    rdy_in = 1'b0;
    set_src(0, 1'b1, 4'd4, 32'h0BAD_0004);
    #1;
    chk("stall_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("stall_lsb_ready", 32'(bus.lsb_ready), 32'd0);
    chk("stall_br_ready", 32'(bus.br_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_hold_pending", 32'(bus.pending), 32'd2);
      chk("stall_hold_valid", 32'(bus.cdb_valid), 32'd0);
      chk("stall_hold_id", 32'(bus.cdb_rob_id), 32'd10);
    end
    rdy_in = 1'b1;
    idle_all();
    tick();
    chk("stall_drain_lsb", 32'(bus.cdb_src), 32'd1);
    tick();
    chk("stall_drain_br", 32'(bus.cdb_src), 32'd2);
    chk("stall_drain_pending", 32'(bus.pending), 32'd0);

    // Flush with three pending and a BR result offered: everything dropped
    set_src(0, 1'b1, 4'd13, 32'h0000_1313);
    set_src(1, 1'b1, 4'd14, 32'h0000_1414);
    set_src(2, 1'b1, 4'd15, 32'h0000_1515);
    tick();
    chk("flush_pending_full", 32'(bus.pending), 32'd3);
    idle_all();
    set_src(2, 1'b1, 4'd6, 32'h0000_0BAD);
    clear = 1'b1;
    #1;
    chk("flush_br_ready", 32'(bus.br_ready), 32'd0);
    chk("flush_alu_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    clear = 1'b0;
    idle_all();
    chk("flush_valid", 32'(bus.cdb_valid), 32'd0);
    chk("flush_pending", 32'(bus.pending), 32'd0);
    tick();
    chk("flush_quiet", 32'(bus.cdb_valid), 32'd0);

    // Pointer back at ALU after flush; clear ignored while stalled
    set_src(0, 1'b1, 4'd1, 32'h0000_1616);
    set_src(1, 1'b1, 4'd2, 32'h0000_1717);
    push(4'd1, 32'h0000_1616, 2'd0);
    push(4'd2, 32'h0000_1717, 2'd1);
    tick();
    idle_all();
    rdy_in = 1'b0;
    clear  = 1'b1;
    #1;
    chk("stall_clear_ready", 32'(bus.alu_ready), 32'd0);
    tick();
    tick();
    chk("stall_clear_pending", 32'(bus.pending), 32'd2);
    rdy_in = 1'b1;
    clear  = 1'b0;
    tick();
    chk("post_flush_first", 32'(bus.cdb_src), 32'd0);
    tick();
    chk("post_flush_second", 32'(bus.cdb_src), 32'd1);
    tick();
    chk("post_flush_idle", 32'(bus.cdb_valid), 32'd0);

    // Asynchronous reset mid-cycle with holds and bus loaded
    set_src(0, 1'b1, 4'd3, 32'h0000_0333);
    set_src(1, 1'b1, 4'd3, 32'h0000_0334);
    set_src(2, 1'b1, 4'd3, 32'h0000_0335);
    tick();
    idle_all();
    tick();
    chk("pre_reset_valid", 32'(bus.cdb_valid), 32'd1);
    chk("pre_reset_pending", 32'(bus.pending), 32'd2);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.cdb_valid), 32'd0);
    chk("async_rst_pending", 32'(bus.pending), 32'd0);
    chk("async_rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("async_rst_br_ready", 32'(bus.br_ready), 32'd0);
    chk("async_rst_id", 32'(bus.cdb_rob_id), 32'd0);
    tick();
    tick();
    rst_n_in = 1'b1;
    #1;
    chk("release_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    tick();
    chk("release_quiet", 32'(bus.cdb_valid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
